// File: rtl/e_clock_ctrl_if.sv
// Host-side control and status bundle of the SD clock controller.
// master = register block / host model, slave = e_clock_ctrl.
interface e_clock_ctrl_if;
    logic       int_clk_en_req;
    logic       sd_clk_en_req;
    logic [7:0] clock_div_in;
    logic       clock_div_wr;
    logic       buf_stall;
    logic       xfer_active;
    logic       int_clock_en;
    logic       int_clock_stable;
    logic       sd_clock_en;
    logic       sdclk_disable;
    logic [7:0] clock_div;
    logic       load_clock_div_p;

    modport master (
        output int_clk_en_req, sd_clk_en_req, clock_div_in, clock_div_wr,
               buf_stall, xfer_active,
        input  int_clock_en, int_clock_stable, sd_clock_en, sdclk_disable,
               clock_div, load_clock_div_p
    );

    modport slave (
        input  int_clk_en_req, sd_clk_en_req, clock_div_in, clock_div_wr,
               buf_stall, xfer_active,
        output int_clock_en, int_clock_stable, sd_clock_en, sdclk_disable,
               clock_div, load_clock_div_p
    );
endinterface

// File: rtl/e_clock_ctrl.sv
// SD host clock controller: internal clock bring-up, SD clock gating and a
// divider reload wrapped in clock-off guard gaps so the SD clock never glitches.
module e_clock_ctrl #(
    parameter int unsigned STABLE_CNT = 64,
    parameter int unsigned GUARD_CNT  = 4
) (
    input  logic          sd_clk_2x,
    input  logic          rst_n,
    e_clock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF, S_STAB, S_RUN, S_GATE, S_LOAD, S_GUARD
    } state_t;

    localparam logic [15:0] STAB_LOAD  = 16'(STABLE_CNT - 1);
    localparam logic [15:0] GUARD_LOAD = 16'(GUARD_CNT - 1);
    localparam logic [7:0]  DIV_RESET  = 8'h80;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_reload, w_reload_nxt;
    logic [7:0]  r_pending, w_pending_nxt;
    logic [7:0]  r_clock_div, w_clock_div_nxt;
    logic        r_load_p, w_load_p_nxt;
    logic        r_int_clock_en, r_int_clock_stable, r_sd_clock_en, r_sdclk_disable;
    logic        w_idle, w_direct, w_cnt_zero, w_sd_en_nxt;

    assign w_idle      = (r_state == S_OFF) || (r_state == S_STAB);
    assign w_direct    = w_idle || !bus.int_clk_en_req;
    assign w_cnt_zero  = (r_cnt == 16'd0);
    assign w_sd_en_nxt = (w_state_nxt == S_RUN) && bus.sd_clk_en_req;

    always_comb begin
        // NOTE: every w_*_nxt gets a default first, so no path can infer a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_reload_nxt    = r_reload;
        w_clock_div_nxt = r_clock_div;
        w_load_p_nxt    = 1'b0;
        w_pending_nxt   = bus.clock_div_wr ? bus.clock_div_in : r_pending;

        // No SD clock is running here, so the divider is applied at once; a write
        // right after a pulse waits one cycle in pending to keep pulses apart.
        if (w_direct) begin
            if (bus.clock_div_wr && r_load_p) begin
                w_reload_nxt = 1'b1;
            end else if (bus.clock_div_wr || (r_reload && w_idle)) begin
                w_clock_div_nxt = w_pending_nxt;
                w_load_p_nxt    = 1'b1;
                w_reload_nxt    = 1'b0;
            end else begin
                w_reload_nxt = 1'b0;
            end
        end

        if (!bus.int_clk_en_req) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = 16'd0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_STAB;
                    w_cnt_nxt   = STAB_LOAD;
                end
                S_STAB: begin
                    if (w_cnt_zero) w_state_nxt = S_RUN;
                    else            w_cnt_nxt   = r_cnt - 16'd1;
                end
                S_RUN: begin
                    if (bus.clock_div_wr || r_reload) begin
                        w_state_nxt  = S_GATE;
                        w_cnt_nxt    = GUARD_LOAD;
                        w_reload_nxt = 1'b0;
                    end
                end
                S_GATE: begin
                    if (w_cnt_zero) begin
                        w_state_nxt     = S_LOAD;
                        w_clock_div_nxt = w_pending_nxt;
                        w_load_p_nxt    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = GUARD_LOAD;
                    if (bus.clock_div_wr) w_reload_nxt = 1'b1;
                end
                S_GUARD: begin
                    if (w_cnt_zero) begin
                        if (r_reload || bus.clock_div_wr) begin
                            w_state_nxt  = S_GATE;
                            w_cnt_nxt    = GUARD_LOAD;
                            w_reload_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                        if (bus.clock_div_wr) w_reload_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge sd_clk_2x or negedge rst_n) begin
        if (!rst_n) r_state <= S_OFF;
        else        r_state <= w_state_nxt;
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge sd_clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt              <= 16'd0;
            r_reload           <= 1'b0;
            r_pending          <= DIV_RESET;
            r_clock_div        <= DIV_RESET;
            r_load_p           <= 1'b0;
            r_int_clock_en     <= 1'b0;
            r_int_clock_stable <= 1'b0;
            r_sd_clock_en      <= 1'b0;
            r_sdclk_disable    <= 1'b0;
        end else begin
            r_cnt              <= w_cnt_nxt;
            r_reload           <= w_reload_nxt;
            r_pending          <= w_pending_nxt;
            r_clock_div        <= w_clock_div_nxt;
            r_load_p           <= w_load_p_nxt;
            r_int_clock_en     <= (w_state_nxt != S_OFF);
            r_int_clock_stable <= (w_state_nxt != S_OFF) && (w_state_nxt != S_STAB);
            r_sd_clock_en      <= w_sd_en_nxt;
            r_sdclk_disable    <= w_sd_en_nxt && bus.buf_stall && bus.xfer_active;
        end
    end

    assign bus.int_clock_en     = r_int_clock_en;
    assign bus.int_clock_stable = r_int_clock_stable;
    assign bus.sd_clock_en      = r_sd_clock_en;
    assign bus.sdclk_disable    = r_sdclk_disable;
    assign bus.clock_div        = r_clock_div;
    assign bus.load_clock_div_p = r_load_p;
endmodule
